seq_divider: RTL and testbench

Sequential unsigned 128/64 divider, the inverse of the `equation` multiply-accumulate datapath. Given a 128-bit dividend N and a 64-bit divisor D, it returns a 64-bit quotient Q and a 64-bit remainder R such that N = Q*D + R and R < D. It is a radix-2 restoring divider producing one quotient bit per cycle. It uses valid/ready handshakes on both sides and flags divide-by-zero and quotient overflow.

---
 rtl/div_pkg.sv | 9 +
 rtl/div_step.sv | 20 ++
 rtl/seq_divider.sv | 99 +++++++++
 tb/tb_seq_divider.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and types for the sequential 128/64 restoring divider.
package div_pkg;
    localparam int DIV_WN = 128;
    localparam int DIV_WD = 64;

    typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

    localparam logic [DIV_WD-1:0] Q_ALL_ONES = '1;
endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring step: shift in a dividend bit, trial-subtract D.
module div_step import div_pkg::*; #(
    parameter int WD = DIV_WD
) (
    input  logic [WD:0]   p,
    input  logic [WD-1:0] d,
    input  logic          bit_in,
    output logic [WD:0]   p_next,
    output logic          q_bit
);
    logic [WD:0] p_sh;
    logic [WD:0] d_ext;

    always_comb begin
        p_sh   = {p[WD-1:0], bit_in};
        d_ext  = {1'b0, d};
        q_bit  = (p_sh >= d_ext);
        p_next = q_bit ? (p_sh - d_ext) : p_sh;
    end
endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned 128/64 divider, one quotient bit per cycle, valid/ready on both sides.
module seq_divider import div_pkg::*; #(
    parameter int WN = DIV_WN,
    parameter int WD = DIV_WD
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WN-1:0] N,
    input  logic [WD-1:0] D,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WD-1:0] Q,
    output logic [WD-1:0] R,
    output logic          div_by_zero,
    output logic          overflow
);
    localparam int CW = $clog2(WD);

    div_state_t    state;
    logic [WD-1:0] d_q;
    logic [WD-1:0] n_lo_q;
    logic [WD:0]   p_q;
    logic [WD-1:0] qw_q;
    logic [CW-1:0] cnt_q;
    logic [WD:0]   p_next;
    logic          q_bit;

    div_step #(.WD(WD)) u_step (
        .p      (p_q),
        .d      (d_q),
        .bit_in (n_lo_q[WD-1]),
        .p_next (p_next),
        .q_bit  (q_bit)
    );

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            d_q         <= '0;
            n_lo_q      <= '0;
            p_q         <= '0;
            qw_q        <= '0;
            cnt_q       <= '0;
            out_valid   <= 1'b0;
            Q           <= '0;
            R           <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        d_q    <= D;
                        n_lo_q <= N[WD-1:0];
                        if (D == '0 || N[WN-1:WD] >= D) begin
                            Q           <= Q_ALL_ONES;
                            R           <= N[WD-1:0];
                            div_by_zero <= (D == '0);
                            overflow    <= (D != '0);
                            state       <= DONE;
                        end else begin
                            p_q   <= {1'b0, N[WN-1:WD]};
                            qw_q  <= '0;
                            cnt_q <= CW'(WD-1);
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    p_q    <= p_next;
                    qw_q   <= {qw_q[WD-2:0], q_bit};
                    n_lo_q <= {n_lo_q[WD-2:0], 1'b0};
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        Q           <= {qw_q[WD-2:0], q_bit};
                        R           <= p_next[WD-1:0];
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    // Results land on DONE entry; out_valid follows one edge later.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// Directed scoreboard bench for seq_divider: stimulus pushes expectations, monitor pops on output handshake.
module tb_seq_divider;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [127:0]  N = '0;
    logic [63:0]   D = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [63:0]   Q;
    logic [63:0]   R;
    logic          div_by_zero;
    logic          overflow;

    typedef struct packed {
        logic [63:0] q;
        logic [63:0] r;
        logic        dz;
        logic        ov;
    } res_t;

    res_t sb[$];
    res_t mon_e;
    int   n_pass = 0;
    int   n_tot  = 0;

    seq_divider dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .N           (N),
        .D           (D),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .Q           (Q),
        .R           (R),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 128'd1, 128'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("Q", Q, mon_e.q);
                chk("R", R, mon_e.r);
                chk("div_by_zero", div_by_zero, mon_e.dz);
                chk("overflow", overflow, mon_e.ov);
            end
        end
    end

    task automatic issue(input logic [127:0] n, input logic [63:0] d, input logic [63:0] eq,
                         input logic [63:0] er, input logic edz, input logic eov);
        int w;
        w = 0;
        @(posedge clk); #1;
        while (!in_ready && w < 300) begin
            @(posedge clk); #1;
            w++;
        end
        chk("in_ready_before_issue", in_ready, 1'b1);
        N = n;
        D = d;
        in_valid = 1'b1;
        sb.push_back('{q: eq, r: er, dz: edz, ov: eov});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_op(input logic [127:0] n, input logic [63:0] d, input logic [63:0] eq,
                          input logic [63:0] er, input logic edz, input logic eov, input int lat);
        int cnt;
        issue(n, d, eq, er, edz, eov);
        cnt = 0;
        @(negedge clk);
        while (!out_valid && cnt < 200) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
        chk("latency", cnt, lat);
    endtask

    initial begin
        logic [63:0] sq, sr;
        logic        sdz, sov;
        res_t        dropped;

        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_Q", Q, 64'd0);
        chk("rst_R", R, 64'd0);
        chk("rst_flags", {div_by_zero, overflow}, 2'b00);
        #11 rst_n = 1'b1;
        #1 chk("rst_in_ready", in_ready, 1'b1);

        run_op(128'd100, 64'd7, 64'd14, 64'd2, 1'b0, 1'b0, 65);
        run_op(128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b0, 65);
        run_op(128'h1_0000_0000_0000_0000, 64'd2, 64'h8000_0000_0000_0000, 64'd0, 1'b0, 1'b0, 65);
        run_op(128'd5, 64'd9, 64'd0, 64'd5, 1'b0, 1'b0, 65);
        run_op(128'h0026c160f19eb5f182168f26ab92c99b, 64'd0,
               64'hFFFF_FFFF_FFFF_FFFF, 64'h82168f26ab92c99b, 1'b1, 1'b0, 1);
        run_op(128'h1_0000_0000_0000_0000, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b1, 1);

        // Backpressure: result must hold while stray in_valid pulses are ignored.
        @(posedge clk); #1;
        out_ready = 1'b0;
        run_op(128'd1000, 64'd7, 64'd142, 64'd6, 1'b0, 1'b0, 65);
        sq = Q; sr = R; sdz = div_by_zero; sov = overflow;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            N = 128'd77 + 128'(i);
            D = 64'd3;
            @(negedge clk);
            chk("bp_hold", {out_valid, in_ready, Q, R, div_by_zero, overflow},
                {1'b1, 1'b0, sq, sr, sdz, sov});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready", {in_ready, out_valid}, 2'b10);

        // Reset mid-CALC aborts the operation in flight.
        issue(128'd100, 64'd7, 64'd14, 64'd2, 1'b0, 1'b0);
        repeat (29) @(posedge clk);
        #3 rst_n = 1'b0;
        dropped = sb.pop_back();
        #1;
        chk("midrst_outputs", {out_valid, Q, R, div_by_zero, overflow}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 1'b1);
        run_op(128'd100, 64'd7, 64'd14, 64'd2, 1'b0, 1'b0, 65);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
